// File: rtl/jigsaw_net_rx_framer.sv
// Jigsaw RX framer: splits packets into a header beat plus byte-0-aligned payload beats.
// Optional payload length check is built when JIGSAW_RX_LEN_CHECK_EN is defined.
module jigsaw_net_rx_framer #(
    parameter int DATA_BITS  = 512,
    parameter int KEEP_WIDTH = DATA_BITS / 8,
    parameter int HDR_BYTES  = 17
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_BITS-1:0]  s_tdata,
    input  logic [KEEP_WIDTH-1:0] s_tkeep,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    output logic                  s_tready,
    output logic [DATA_BITS-1:0]  m_tdata,
    output logic [KEEP_WIDTH-1:0] m_tkeep,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    input  logic                  m_tready,
    output logic [31:0]           drop_cnt,
    output logic                  len_err
);

    localparam int HDR_BITS = HDR_BYTES * 8;
    localparam int RES_BITS = DATA_BITS - HDR_BITS;
    localparam int RES_KEEP = KEEP_WIDTH - HDR_BYTES;

    localparam logic [7:0] OP_DMA_RD   = 8'd0;
    localparam logic [7:0] OP_WRITE    = 8'd1;
    localparam logic [7:0] OP_MMIO_RSP = 8'd2;

    typedef enum logic [1:0] {ST_HDR, ST_PAY, ST_FLUSH, ST_DROP} state_t;

    state_t                state, state_next;
    logic [RES_BITS-1:0]   res_data, res_data_next;
    logic [RES_KEEP-1:0]   res_keep, res_keep_next;
    logic                  out_free, accept, load, drop_inc;
    logic [DATA_BITS-1:0]  out_data;
    logic [KEEP_WIDTH-1:0] out_keep;
    logic                  out_last;
    logic [7:0]            op;
    logic [RES_KEEP-1:0]   in_res_keep;

    assign op          = s_tdata[7:0];
    assign in_res_keep = s_tkeep[KEEP_WIDTH-1:HDR_BYTES];
    assign out_free    = !m_tvalid || m_tready;
    assign accept      = s_tvalid && s_tready;

    always_comb begin
        s_tready = 1'b0;
        case (state)
            ST_HDR, ST_PAY: s_tready = out_free;
            ST_FLUSH:       s_tready = 1'b0;
            ST_DROP:        s_tready = 1'b1;
            default:        s_tready = 1'b0;
        endcase
    end

    always_comb begin
        state_next    = state;
        res_data_next = res_data;
        res_keep_next = res_keep;
        load          = 1'b0;
        drop_inc      = 1'b0;
        out_data      = '0;
        out_keep      = '0;
        out_last      = 1'b0;
        case (state)
            ST_HDR: begin
                if (accept) begin
                    if (op == OP_DMA_RD || op == OP_MMIO_RSP) begin
                        load     = 1'b1;
                        out_data = {{RES_BITS{1'b0}}, s_tdata[HDR_BITS-1:0]};
                        out_keep = {{RES_KEEP{1'b0}}, {HDR_BYTES{1'b1}}};
                        out_last = 1'b1;
                        if (!s_tlast) state_next = ST_DROP;
                    end else if (op == OP_WRITE) begin
                        load          = 1'b1;
                        out_data      = {{RES_BITS{1'b0}}, s_tdata[HDR_BITS-1:0]};
                        out_keep      = {{RES_KEEP{1'b0}}, {HDR_BYTES{1'b1}}};
                        res_data_next = s_tdata[DATA_BITS-1:HDR_BITS];
                        res_keep_next = in_res_keep;
                        if (!s_tlast)          state_next = ST_PAY;
                        else if (|in_res_keep) state_next = ST_FLUSH;
                        else                   out_last   = 1'b1;
                    end else begin
                        drop_inc = 1'b1;
                        if (!s_tlast) state_next = ST_DROP;
                    end
                end
            end
            ST_PAY: begin
                if (accept) begin
                    load          = 1'b1;
                    out_data      = {s_tdata[HDR_BITS-1:0], res_data};
                    out_keep      = {s_tkeep[HDR_BYTES-1:0], res_keep};
                    res_data_next = s_tdata[DATA_BITS-1:HDR_BITS];
                    res_keep_next = in_res_keep;
                    if (s_tlast) begin
                        if (|in_res_keep) begin
                            state_next = ST_FLUSH;
                        end else begin
                            out_last   = 1'b1;
                            state_next = ST_HDR;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (out_free) begin
                    load       = 1'b1;
                    out_data   = {{HDR_BITS{1'b0}}, res_data};
                    out_keep   = {{HDR_BYTES{1'b0}}, res_keep};
                    out_last   = 1'b1;
                    state_next = ST_HDR;
                end
            end
            ST_DROP: begin
                if (accept && s_tlast) state_next = ST_HDR;
            end
            default: state_next = ST_HDR;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= ST_HDR;
            res_data <= '0;
            res_keep <= '0;
            drop_cnt <= '0;
        end else begin
            state    <= state_next;
            res_data <= res_data_next;
            res_keep <= res_keep_next;
            if (drop_inc) drop_cnt <= drop_cnt + 32'd1;
        end
    end

    // Single output register stage; contents are held whenever the sink stalls.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
        end else if (out_free) begin
            m_tvalid <= load;
            if (load) begin
                m_tdata <= out_data;
                m_tkeep <= out_keep;
                m_tlast <= out_last;
            end
        end
    end

`ifdef JIGSAW_RX_LEN_CHECK_EN
    localparam int POP_W = $clog2(KEEP_WIDTH + 1);

    function automatic logic [POP_W-1:0] popcount(input logic [KEEP_WIDTH-1:0] k);
        logic [POP_W-1:0] c;
        c = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) c = c + POP_W'(k[i]);
        return c;
    endfunction

    logic        wr_hdr, pay_beat;
    logic [63:0] len_cap, byte_sum, byte_sum_next, len_ref;

    assign wr_hdr        = (state == ST_HDR) && accept && (op == OP_WRITE);
    assign pay_beat      = load && ((state == ST_PAY) || (state == ST_FLUSH));
    assign byte_sum_next = wr_hdr ? 64'd0 : byte_sum + 64'(popcount(out_keep));
    assign len_ref       = wr_hdr ? s_tdata[HDR_BITS-1:HDR_BITS-64] : len_cap;

    // len_err rises together with the registered tlast beat of a write packet.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            len_cap  <= '0;
            byte_sum <= '0;
            len_err  <= 1'b0;
        end else begin
            len_err <= 1'b0;
            if (wr_hdr || pay_beat) begin
                byte_sum <= byte_sum_next;
                if (wr_hdr)   len_cap <= s_tdata[HDR_BITS-1:HDR_BITS-64];
                if (out_last) len_err <= (byte_sum_next != len_ref);
            end
        end
    end
`else
    assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_jigsaw_net_rx_framer.sv
// Self-checking bench for jigsaw_net_rx_framer: byte-level packet model feeding a scoreboard queue.
// Expects len_err pulses only when built with JIGSAW_RX_LEN_CHECK_EN.
module tb_jigsaw_net_rx_framer;

    localparam int DB = 512;
    localparam int KW = 64;
`ifdef JIGSAW_RX_LEN_CHECK_EN
    localparam bit LEN_CHK = 1'b1;
`else
    localparam bit LEN_CHK = 1'b0;
`endif

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [DB-1:0] s_tdata = '0;
    logic [KW-1:0] s_tkeep = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic          s_tready;
    logic [DB-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready = 1'b1;
    logic [31:0]   drop_cnt;
    logic          len_err;

    jigsaw_net_rx_framer #(.DATA_BITS(DB), .KEEP_WIDTH(KW), .HDR_BYTES(17)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
        .m_tready(m_tready),
        .drop_cnt(drop_cnt), .len_err(len_err)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [DB-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          lerr;
    } beat_t;

    typedef struct {
        logic [7:0]  op;
        logic [63:0] addr;
        logic [63:0] len;
        int          pay_n;
        int          exp_beats;
        int          exp_drops;
    } vec_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    out_beats = 0;
    bit    rand_mode = 1'b0;

    task automatic checkOutput(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic abort_run(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s timed out", name);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    function automatic logic [KW-1:0] keep_of(input int nb);
        logic [KW-1:0] k;
        k = (nb >= KW) ? {KW{1'b1}} : ((64'd1 << nb) - 64'd1);
        return k;
    endfunction

    task automatic drive_beat(input logic [DB-1:0] d, input logic [KW-1:0] k, input logic l);
        int n;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tvalid = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!s_tready) begin
            n++;
            if (n > 1000) abort_run("s_tready_wait");
            @(negedge aclk);
        end
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = 1'b0;
    endtask

    // Builds the byte image of one packet, queues the expected output beats, then drives it.
    task automatic applyStimulus(input logic [7:0] op, input logic [63:0] addr,
                                 input logic [63:0] len, input int pay_n);
        logic [7:0]    pkt[$];
        beat_t         e;
        logic [DB-1:0] d;
        int            total, nb;
        pkt.push_back(op);
        for (int i = 0; i < 8; i++) pkt.push_back(addr[8*i +: 8]);
        for (int i = 0; i < 8; i++) pkt.push_back(len[8*i +: 8]);
        for (int i = 0; i < pay_n; i++) pkt.push_back(8'($urandom));

        if (op == 8'd0 || op == 8'd1 || op == 8'd2) begin
            e.data = '0;
            for (int i = 0; i < 17; i++) e.data[8*i +: 8] = pkt[i];
            e.keep = keep_of(17);
            e.last = (op != 8'd1) || (pay_n == 0);
            e.lerr = LEN_CHK && (op == 8'd1) && (pay_n == 0) && (len != 64'd0);
            exp_q.push_back(e);
            if (op == 8'd1) begin
                for (int c = 0; c * 64 < pay_n; c++) begin
                    nb = (pay_n - 64 * c > 64) ? 64 : pay_n - 64 * c;
                    e.data = '0;
                    for (int i = 0; i < nb; i++) e.data[8*i +: 8] = pkt[17 + 64 * c + i];
                    e.keep = keep_of(nb);
                    e.last = (64 * c + nb == pay_n);
                    e.lerr = LEN_CHK && e.last && (len != 64'(pay_n));
                    exp_q.push_back(e);
                end
            end
        end

        total = pkt.size();
        for (int b = 0; b * 64 < total; b++) begin
            nb = (total - 64 * b > 64) ? 64 : total - 64 * b;
            d  = '0;
            for (int i = 0; i < nb; i++) d[8*i +: 8] = pkt[64 * b + i];
            drive_beat(d, keep_of(nb), (64 * b + nb == total));
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        @(negedge aclk);
        while (exp_q.size() != 0 || m_tvalid) begin
            n++;
            if (n > 500) abort_run("output_drain");
            @(negedge aclk);
        end
        @(posedge aclk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            m_tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: stall stability, len_err alignment, and scoreboard pop on handshake.
    initial begin
        logic          prev_stall;
        logic [DB-1:0] prev_data;
        logic [KW-1:0] prev_keep;
        logic          prev_last;
        beat_t         e;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_keep  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checkOutput("stall_valid", m_tvalid, 1'b1);
                    checkOutput("stall_data", m_tdata, prev_data);
                    checkOutput("stall_keep", m_tkeep, prev_keep);
                    checkOutput("stall_last", m_tlast, prev_last);
                end
                if (m_tvalid && !prev_stall) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_beat got %h want no beat", m_tdata);
                    end else begin
                        checkOutput("len_err", len_err, exp_q[0].lerr);
                    end
                end else if (len_err) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL stray_len_err got 1 want 0");
                end
                if (m_tvalid && m_tready) begin
                    out_beats++;
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        checkOutput("out_data", m_tdata, e.data);
                        checkOutput("out_keep", m_tkeep, e.keep);
                        checkOutput("out_last", m_tlast, e.last);
                    end
                end
                prev_stall = m_tvalid && !m_tready;
                prev_data  = m_tdata;
                prev_keep  = m_tkeep;
                prev_last  = m_tlast;
            end
        end
    end

    initial begin
        #500000;
        abort_run("global_watchdog");
    end

    initial begin
        vec_t          vecs[14];
        beat_t         e;
        logic [DB-1:0] d;
        int            b0, tab_drops, exp_rand, pay;

        vecs[0]  = '{8'h00, 64'h1000, 64'd64,  0,   1, 0};
        vecs[1]  = '{8'h01, 64'h2000, 64'd64,  64,  2, 0};
        vecs[2]  = '{8'h01, 64'h3000, 64'd100, 100, 3, 0};
        vecs[3]  = '{8'h07, 64'h4000, 64'd150, 150, 0, 1};
        vecs[4]  = '{8'h02, 64'h5000, 64'd0,   0,   1, 0};
        vecs[5]  = '{8'h01, 64'h6000, 64'd0,   0,   1, 0};
        vecs[6]  = '{8'h01, 64'h7000, 64'd47,  47,  2, 0};
        vecs[7]  = '{8'h00, 64'h8000, 64'd100, 100, 1, 0};
        vecs[8]  = '{8'h01, 64'h9000, 64'd30,  30,  2, 0};
        vecs[9]  = '{8'h01, 64'hA000, 64'd200, 200, 5, 0};
        vecs[10] = '{8'h03, 64'hB000, 64'd0,   0,   0, 1};
        vecs[11] = '{8'h01, 64'hC000, 64'd111, 111, 3, 0};
        vecs[12] = '{8'h01, 64'hD000, 64'd100, 99,  3, 0};
        vecs[13] = '{8'h02, 64'hE000, 64'd40,  40,  1, 0};

        repeat (3) @(posedge aclk);
        #1;
        checkOutput("rst_m_tvalid", m_tvalid, 1'b0);
        checkOutput("rst_m_tdata", m_tdata, '0);
        checkOutput("rst_m_tkeep", m_tkeep, '0);
        checkOutput("rst_m_tlast", m_tlast, 1'b0);
        checkOutput("rst_s_tready", s_tready, 1'b1);
        checkOutput("rst_drop_cnt", drop_cnt, '0);
        checkOutput("rst_len_err", len_err, 1'b0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        tab_drops = 0;
        for (int i = 0; i < 14; i++) begin
            b0 = out_beats;
            applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].len, vecs[i].pay_n);
            wait_drain();
            tab_drops += vecs[i].exp_drops;
            checkOutput($sformatf("vec%0d_beats", i), out_beats - b0, vecs[i].exp_beats);
            checkOutput($sformatf("vec%0d_drop_cnt", i), drop_cnt, tab_drops);
        end

        // Registered output: an accepted header is visible one edge later.
        applyStimulus(8'h02, 64'h1234, 64'd0, 0);
        checkOutput("latency_valid", m_tvalid, 1'b1);
        wait_drain();

        rand_mode = 1'b1;
        exp_rand  = 0;
        b0        = out_beats;
        for (int p = 0; p < 20; p++) begin
            pay = $urandom_range(0, 200);
            exp_rand += 1 + (pay + 63) / 64;
            applyStimulus(8'h01, {32'h0, $urandom}, 64'(pay), pay);
        end
        wait_drain();
        rand_mode = 1'b0;
        checkOutput("random_total_beats", out_beats - b0, exp_rand);

        // Reset in the middle of a write packet, then a fresh op 2 must come through intact.
        @(posedge aclk);
        #1;
        d = '0;
        d[7:0]    = 8'h01;
        d[71:8]   = 64'hFEED;
        d[135:72] = 64'd100;
        for (int i = 17; i < 64; i++) d[8*i +: 8] = 8'($urandom);
        e.data = '0;
        e.data[135:0] = d[135:0];
        e.keep = keep_of(17);
        e.last = 1'b0;
        e.lerr = 1'b0;
        exp_q.push_back(e);
        drive_beat(d, keep_of(64), 1'b0);
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        #2;
        checkOutput("midrst_m_tvalid", m_tvalid, 1'b0);
        checkOutput("midrst_drop_cnt", drop_cnt, '0);
        checkOutput("midrst_s_tready", s_tready, 1'b1);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        b0 = out_beats;
        applyStimulus(8'h02, 64'h55AA, 64'd8, 0);
        wait_drain();
        checkOutput("post_reset_beats", out_beats - b0, 1);
        checkOutput("post_reset_drop_cnt", drop_cnt, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
